// File: rtl/vscale_hasti_sram_ws.sv
// AHB-Lite (HASTI) SRAM slave with programmable wait states and natural byte-lane writes.
// Define VSCALE_SRAM_ERRCHK_EN to answer out-of-range, illegal-size or misaligned beats with ERROR.
module vscale_hasti_sram_ws #(
    parameter int NWORDS      = 1024,
    parameter int WAIT_STATES = 0
) (
    input  logic        hclk,
    input  logic        hresetn,
    input  logic [31:0] haddr,
    input  logic        hwrite,
    input  logic [2:0]  hsize,
    input  logic [2:0]  hburst,
    input  logic        hmastlock,
    input  logic [3:0]  hprot,
    input  logic [1:0]  htrans,
    input  logic [31:0] hwdata,
    output logic [31:0] hrdata,
    output logic        hready,
    output logic        hresp
);
    localparam int AW = $clog2(NWORDS);
    localparam logic [2:0] WS_M1 = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_DONE = 3'd2,
        ST_ERR  = 3'd3,
        ST_ERR2 = 3'd4
    } state_t;

    function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] lo);
        logic [3:0] m;
        case (size)
            3'd0:    m = 4'b0001 << lo;
            3'd1:    m = 4'b0011 << {lo[1], 1'b0};
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

`ifdef VSCALE_SRAM_ERRCHK_EN
    function automatic logic xfer_err(input logic [31:0] addr, input logic [2:0] size);
        return (addr[31:2] >= 30'(NWORDS)) || (size > 3'd2) ||
               ((size == 3'd1) && addr[0]) || ((size == 3'd2) && (addr[1:0] != 2'd0));
    endfunction
`endif

    state_t          state_q, state_d;
    logic [2:0]      cnt_q, cnt_d;
    logic            pend_q, pend_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic [3:0]      mask_q, mask_d;
    logic            write_q, write_d;
    logic            hready_q, hready_d;
    logic            hresp_q, hresp_d;
    logic [31:0]     mem_q [NWORDS];

    logic            accept_s;
    logic            err_s;
    logic            we_s;
    logic            rd_en_s;
    logic            unused_s;

    assign accept_s = hready_q & htrans[1];
`ifdef VSCALE_SRAM_ERRCHK_EN
    assign err_s    = xfer_err(haddr, hsize);
`else
    assign err_s    = 1'b0;
`endif
    // A write lands only on the completing edge of an OKAY data phase.
    assign we_s     = pend_q & write_q & hready_q & ~hresp_q;
    assign rd_en_s  = pend_q & ~write_q & ~hresp_q;
    assign hrdata   = rd_en_s ? mem_q[idx_q] : 32'h0000_0000;
    assign hready   = hready_q;
    assign hresp    = hresp_q;
    assign unused_s = ^{hburst, hmastlock, hprot, htrans[0], haddr};

    // Next-state logic: data-phase sequencing and address-phase capture.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        idx_d   = idx_q;
        mask_d  = mask_q;
        write_d = write_q;
        case (state_q)
            ST_WAIT: begin
                if (cnt_q == 3'd0) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            ST_ERR: begin
                state_d = ST_ERR2;
            end
            ST_IDLE, ST_DONE, ST_ERR2: begin
                if (accept_s) begin
                    pend_d  = 1'b1;
                    idx_d   = haddr[AW+1:2];
                    mask_d  = lane_mask(hsize, haddr[1:0]);
                    write_d = hwrite;
                    if (err_s) begin
                        state_d = ST_ERR;
                    end else if (WAIT_STATES > 0) begin
                        state_d = ST_WAIT;
                        cnt_d   = WS_M1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_IDLE;
                    pend_d  = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                pend_d  = 1'b0;
            end
        endcase
        if ((state_d == ST_WAIT) || (state_d == ST_ERR)) begin
            hready_d = 1'b0;
        end else begin
            hready_d = 1'b1;
        end
        if ((state_d == ST_ERR) || (state_d == ST_ERR2)) begin
            hresp_d = 1'b1;
        end else begin
            hresp_d = 1'b0;
        end
    end

    // Controller state and registered bus responses.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 3'd0;
            pend_q   <= 1'b0;
            idx_q    <= '0;
            mask_q   <= 4'b0000;
            write_q  <= 1'b0;
            hready_q <= 1'b1;
            hresp_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pend_q   <= pend_d;
            idx_q    <= idx_d;
            mask_q   <= mask_d;
            write_q  <= write_d;
            hready_q <= hready_d;
            hresp_q  <= hresp_d;
        end
    end

    // Storage array keeps its contents across reset, so it has no reset branch.
    always_ff @(posedge hclk) begin
        for (int b = 0; b < 4; b++) begin
            if (we_s && mask_q[b]) begin
                mem_q[idx_q][8*b +: 8] <= hwdata[8*b +: 8];
            end
        end
    end
endmodule

// File: tb/tb_vscale_hasti_sram_ws.sv
// Directed bench for vscale_hasti_sram_ws: four instances with WAIT_STATES 0..3, checked every cycle
// against a transfer-level model (expected response queue plus shadow memory).
module tb_vscale_hasti_sram_ws;
    localparam int NW = 1024;
    localparam int NI = 4;

    typedef struct packed {
        logic        rdy;
        logic        resp;
        logic        chk;
        logic [31:0] data;
    } exp_t;

    logic        hclk;
    logic        hresetn;
    logic [31:0] haddr_s  [NI];
    logic        hwrite_s [NI];
    logic [2:0]  hsize_s  [NI];
    logic [1:0]  htrans_s [NI];
    logic [31:0] hwdata_s [NI];
    logic [31:0] hrdata_o [NI];
    logic        hready_o [NI];
    logic        hresp_o  [NI];

    logic        snap_rdy  [NI];
    logic        snap_resp [NI];
    logic [31:0] snap_rd   [NI];
    bit   [31:0] mem_m [NI][NW];
    exp_t        exp_q[$];
    int          act;
    int          errors;
    int          checks;
    int          low_cnt;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        vscale_hasti_sram_ws #(.NWORDS(NW), .WAIT_STATES(g)) u_dut (
            .hclk      (hclk),
            .hresetn   (hresetn),
            .haddr     (haddr_s[g]),
            .hwrite    (hwrite_s[g]),
            .hsize     (hsize_s[g]),
            .hburst    (3'd0),
            .hmastlock (1'b0),
            .hprot     (4'd0),
            .htrans    (htrans_s[g]),
            .hwdata    (hwdata_s[g]),
            .hrdata    (hrdata_o[g]),
            .hready    (hready_o[g]),
            .hresp     (hresp_o[g])
        );
    end

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, got, want);
        end
    endtask

    function automatic bit lane_hit(input int b, input logic [1:0] lo, input logic [2:0] sz);
        if (sz == 3'd0) return b == int'(lo);
        if (sz == 3'd1) return (b / 2) == int'(lo[1]);
        return 1'b1;
    endfunction

    // Transfer-level model: instance k has k wait states; an accepted beat contributes its data-phase cycles.
    task automatic model_push(input int k, input logic [31:0] a, input logic w, input logic [2:0] sz,
                              input logic [31:0] wd);
        int   idx;
        logic err;
        idx = int'((a >> 2) % 32'(NW));
`ifdef VSCALE_SRAM_ERRCHK_EN
        err = (a >= 32'(NW * 4)) || (sz > 3'd2) || (sz == 3'd1 && a[0]) || (sz == 3'd2 && a[1:0] != 2'd0);
`else
        err = 1'b0;
`endif
        if (err) begin
            exp_q.push_back({1'b0, 1'b1, 1'b1, 32'h0});
            exp_q.push_back({1'b1, 1'b1, 1'b1, 32'h0});
        end else begin
            for (int i = 0; i < k; i++) exp_q.push_back({1'b0, 1'b0, w, 32'h0});
            if (w) begin
                for (int b = 0; b < 4; b++)
                    if (lane_hit(b, a[1:0], sz)) mem_m[k][idx][8*b +: 8] = wd[8*b +: 8];
                exp_q.push_back({1'b1, 1'b0, 1'b1, 32'h0});
            end else begin
                exp_q.push_back({1'b1, 1'b0, 1'b1, mem_m[k][idx]});
            end
        end
    endtask

    // One clock: compare every instance against the model at the falling edge, return 1ns after the rising edge.
    task automatic cycle();
        exp_t e;
        @(negedge hclk);
        for (int k = 0; k < NI; k++) begin
            snap_rdy[k]  = hready_o[k];
            snap_resp[k] = hresp_o[k];
            snap_rd[k]   = hrdata_o[k];
            e = {1'b1, 1'b0, 1'b1, 32'h0};
            if (k == act && exp_q.size() > 0) e = exp_q.pop_front();
            if (k == act && !hready_o[k]) low_cnt++;
            chk($sformatf("hready[%0d]", k), {31'h0, hready_o[k]}, {31'h0, e.rdy});
            chk($sformatf("hresp[%0d]", k), {31'h0, hresp_o[k]}, {31'h0, e.resp});
            if (e.chk) chk($sformatf("hrdata[%0d]", k), hrdata_o[k], e.data);
        end
        @(posedge hclk);
        #1;
    endtask

    task automatic xfer(input int k, input logic [1:0] tr, input logic [31:0] a, input logic w,
                        input logic [2:0] sz, input logic [31:0] wd);
        int n;
        bit done;
        htrans_s[k] = tr;
        haddr_s[k]  = a;
        hwrite_s[k] = w;
        hsize_s[k]  = sz;
        n = 0;
        done = 1'b0;
        while (!done) begin
            cycle();
            if (snap_rdy[k]) begin
                done = 1'b1;
            end else begin
                n++;
                if (n > 20) begin
                    checks++;
                    errors++;
                    $display("FAIL accept_timeout inst %0d: got %0d stalled cycles want at most 20", k, n);
                    done = 1'b1;
                end
            end
        end
        if (tr[1]) begin
            model_push(k, a, w, sz, wd);
            if (w) hwdata_s[k] = wd;
        end
    endtask

    task automatic dphase(input int k, output int nlow, output logic resp, output logic [31:0] rd);
        bit done;
        nlow = 0;
        resp = 1'b0;
        rd = 32'h0;
        done = 1'b0;
        htrans_s[k] = 2'd0;
        while (!done) begin
            cycle();
            if (snap_rdy[k]) begin
                resp = snap_resp[k];
                rd = snap_rd[k];
                done = 1'b1;
            end else begin
                nlow++;
                if (nlow > 20) begin
                    checks++;
                    errors++;
                    $display("FAIL dphase_timeout inst %0d: got %0d stall cycles want at most 20", k, nlow);
                    done = 1'b1;
                end
            end
        end
    endtask

    task automatic rd_chk(input int k, input logic [31:0] a, input logic [2:0] sz, input logic [31:0] want,
                          input int want_low, input logic want_resp, input string nm);
        int n;
        logic r;
        logic [31:0] d;
        xfer(k, 2'd2, a, 1'b0, sz, 32'h0);
        dphase(k, n, r, d);
        chk({nm, "_rdata"}, d, want);
        chk({nm, "_stall"}, 32'(n), 32'(want_low));
        chk({nm, "_resp"}, {31'h0, r}, {31'h0, want_resp});
    endtask

    initial begin
        int n;
        int base;
        logic r;
        logic [31:0] d;
        errors = 0;
        checks = 0;
        low_cnt = 0;
        act = 0;
        hresetn = 1'b0;
        for (int k = 0; k < NI; k++) begin
            haddr_s[k] = 32'h0; hwrite_s[k] = 1'b0; hsize_s[k] = 3'd2;
            htrans_s[k] = 2'd0; hwdata_s[k] = 32'h0;
        end
        repeat (2) @(posedge hclk);
        #1;
        chk("reset_hready", {31'h0, hready_o[0]}, 32'd1);
        chk("reset_hrdata", hrdata_o[0], 32'h0);
        hresetn = 1'b1;
        cycle();

        // Back-to-back beats with no wait states and a byte merge.
        act = 0;
        base = low_cnt;
        xfer(0, 2'd2, 32'h8, 1'b1, 3'd2, 32'h1122_3344);
        xfer(0, 2'd3, 32'h9, 1'b1, 3'd0, 32'h0000_AA00);
        rd_chk(0, 32'h8, 3'd2, 32'h1122_AA44, 0, 1'b0, "b2b");
        chk("b2b_total_stall", 32'(low_cnt - base), 32'd0);

        // Two wait states: halfword write then word read.
        act = 2;
        xfer(2, 2'd2, 32'h4, 1'b1, 3'd2, 32'h0);
        dphase(2, n, r, d);
        base = low_cnt;
        xfer(2, 2'd2, 32'h6, 1'b1, 3'd1, 32'hBEEF_0000);
        rd_chk(2, 32'h4, 3'd2, 32'hBEEF_0000, 2, 1'b0, "ws2");
        chk("ws2_total_stall", 32'(low_cnt - base), 32'd4);

        // One wait state with BUSY and IDLE beats interleaved.
        act = 1;
        base = low_cnt;
        xfer(1, 2'd2, 32'h20, 1'b1, 3'd2, 32'h0000_0001);
        xfer(1, 2'd1, 32'h24, 1'b0, 3'd2, 32'h0);
        xfer(1, 2'd3, 32'h24, 1'b1, 3'd2, 32'h0000_0002);
        xfer(1, 2'd0, 32'h28, 1'b0, 3'd2, 32'h0);
        rd_chk(1, 32'h20, 3'd2, 32'h0000_0001, 1, 1'b0, "seq");
        chk("seq_total_stall", 32'(low_cnt - base), 32'd3);
        rd_chk(1, 32'h24, 3'd2, 32'h0000_0002, 1, 1'b0, "seq2");

        // Reset in the second wait cycle drops the pending write.
        act = 3;
        xfer(3, 2'd2, 32'h10, 1'b1, 3'd2, 32'h0);
        dphase(3, n, r, d);
        chk("ws3_wr_stall", 32'(n), 32'd3);
        xfer(3, 2'd2, 32'h10, 1'b1, 3'd2, 32'hDEAD_BEEF);
        htrans_s[3] = 2'd0;
        cycle();
        #2;
        hresetn = 1'b0;
        exp_q.delete();
        mem_m[3][4] = 32'h0;
        #1;
        chk("rst_async_hready", {31'h0, hready_o[3]}, 32'd1);
        chk("rst_async_hresp", {31'h0, hresp_o[3]}, 32'd0);
        cycle();
        hresetn = 1'b1;
        cycle();
        rd_chk(3, 32'h10, 3'd2, 32'h0, 3, 1'b0, "rst_rd");

`ifdef VSCALE_SRAM_ERRCHK_EN
        // Error responses: two cycles regardless of wait states, no write, zero read data.
        act = 2;
        xfer(2, 2'd2, 32'h0, 1'b1, 3'd2, 32'h0000_0055);
        dphase(2, n, r, d);
        xfer(2, 2'd2, 32'h1000, 1'b1, 3'd2, 32'hFFFF_FFFF);
        dphase(2, n, r, d);
        chk("oor_stall", 32'(n), 32'd1);
        chk("oor_resp", {31'h0, r}, 32'd1);
        chk("oor_rdata", d, 32'h0);
        rd_chk(2, 32'h0, 3'd2, 32'h0000_0055, 2, 1'b0, "after_err");
        rd_chk(2, 32'h2, 3'd2, 32'h0, 1, 1'b1, "err_misalign");
        rd_chk(2, 32'h0, 3'd3, 32'h0, 1, 1'b1, "err_size");
`else
        // Without error checking: address wraps, size 3 acts as word, misaligned halfword keeps upper lanes.
        act = 0;
        xfer(0, 2'd2, 32'h1000, 1'b1, 3'd2, 32'hCAFE_F00D);
        xfer(0, 2'd2, 32'h4, 1'b1, 3'd3, 32'h0102_0304);
        xfer(0, 2'd2, 32'hC, 1'b1, 3'd2, 32'h0);
        xfer(0, 2'd2, 32'hF, 1'b1, 3'd1, 32'h1234_5678);
        dphase(0, n, r, d);
        rd_chk(0, 32'h0, 3'd2, 32'hCAFE_F00D, 0, 1'b0, "wrap");
        rd_chk(0, 32'h4, 3'd2, 32'h0102_0304, 0, 1'b0, "size3");
        rd_chk(0, 32'hC, 3'd2, 32'h1234_0000, 0, 1'b0, "mis_half");
`endif
        cycle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/vscale_hasti_sram_ws.md
# vscale_hasti_sram_ws

Parametrised AHB-Lite (HASTI) SRAM slave with programmable wait states, natural-lane byte/halfword/word access and optional address/size error responses. It is the next generation of the core-local SRAM: same bus position (slave on the vscale HASTI interconnect, serving imem/dmem), but with configurable depth and latency and a proper multi-cycle data phase driven by `hready`.

## Interface
- `NWORDS`, 1024, memory depth in 32-bit words; power of two, ≥ 4.
- `WAIT_STATES`, 0, extra data-phase cycles with `hready`=0 per OKAY transfer; range 0..7.
- `hclk` in 1: clock; all state on rising edge.
- `hresetn` in 1: reset, asynchronous, active-low.
- `haddr` in 32: byte address (address phase).
- `hwrite` in 1: 1 = write.
- `hsize` in 3: 0 byte, 1 halfword, 2 word; 3..7 are illegal.
- `hburst` in 3: ignored; each beat is treated independently.
- `hmastlock` in 1: ignored.
- `hprot` in 4: ignored.
- `htrans` in 2: 0 IDLE, 1 BUSY, 2 NONSEQ, 3 SEQ.
- `hwdata` in 32: write data (data phase), natural byte lanes.
- `hrdata` out 32: read data, full word on natural lanes.
- `hready` out 1: data phase complete.
- `hresp` out 1: 0 OKAY, 1 ERROR.

## Operation
- Address phase accepted on a rising edge where `hready`=1 and `htrans[1]`=1. The slave captures word index `haddr[2+AW-1:2]` (AW = log2 NWORDS), `haddr[1:0]`, `hsize` and `hwrite`, and sets `pend`. IDLE/BUSY beats capture nothing and cost zero wait states.
- Byte mask:
  - byte: `4'b0001 << haddr[1:0]`
  - halfword: `4'b0011 << {haddr[1],0}`
  - word: `4'b1111`
- Reads: `hrdata` = `mem[idx]` for the whole word. The master selects lanes. No lane muxing is done.
- Writes: lanes of `hwdata` set in the mask are written on the edge that completes the data phase (`hready`=1). Unmasked lanes are unchanged.
- FSM:
  - IDLE: `hready`=1, `hresp`=0.
  - On accept, next state is chosen in this order:
    - error → ERR;
    - else if `WAIT_STATES`>0 → WAIT with `cnt`=`WAIT_STATES`-1;
    - else stay in IDLE (data phase completes in the next cycle).
  - WAIT: `hready`=0. If `cnt`=0 → DONE, else `cnt`-1.
  - DONE: `hready`=1, `hresp`=0. The write commits at this edge. A new accept is allowed at the same edge and follows the IDLE rules.
  - ERR: `hready`=0, `hresp`=1. Next state is ERR2.
  - ERR2: `hready`=1, `hresp`=1. A new accept is allowed and follows the IDLE rules.
- Any ERROR transfer: no memory write. `hrdata` = 0.
- Read-after-write to the same word, back-to-back: the read returns the post-write value. The write commits before the read's data phase, so no hazard exists.
- Address phase presented while `hready`=0: ignored. The master holds it per protocol.

## Timing
- Reset (async assert): state IDLE, `pend`=0, `cnt`=0, `hready`=1, `hresp`=0, `hrdata`=0. Memory contents are retained.
- A pending write interrupted by reset is dropped.
- `hrdata` = 0 whenever there is no pending read.
- OKAY latency: the data phase lasts `1+WAIT_STATES` cycles after the address-phase edge.
- ERROR: always exactly 2 data-phase cycles, with `WAIT_STATES` not applied.
- `hready`, `hresp` and `hrdata` are functions of registered state and memory only. There are no combinational paths from `h*` inputs.
- Back-to-back NONSEQ/SEQ beats at `WAIT_STATES`=0: one transfer per cycle, with `hready` held at 1.

## Configuration
- `VSCALE_SRAM_ERRCHK_EN` defined: a transfer is an error if any of the following holds:
  - `haddr[31:2]` ≥ `NWORDS`;
  - `hsize` > 2;
  - halfword with `haddr[0]`=1;
  - word with `haddr[1:0]`≠0.
  
  An error transfer takes the ERR/ERR2 path.
- Not defined: there are never errors and `hresp` is tied to 0.
  - The address wraps modulo `NWORDS`.
  - `hsize` > 2 is treated as word.
  - Misaligned accesses use the mask above truncated to 4 bits. Lanes above 3 are dropped.

## Test plan
- Reset mid-WAIT (`WAIT_STATES`=3, write 0xDEADBEEF to 0x10, assert `hresetn` low in the second wait cycle) → `hready`=1, `hresp`=0 immediately, and a later read of 0x10 returns its old value 0.
- `WAIT_STATES`=0: write word 0x11223344 to 0x8, then byte 0xAA at 0x9, then read 0x8 back-to-back → `hready` never low, and the read returns 0x1122AA44.
- `WAIT_STATES`=2: halfword write 0xBEEF at 0x6, then read 0x4 → each beat has `hready` low for 2 cycles, and the read returns 0xBEEF0000.
- `VSCALE_SRAM_ERRCHK_EN`, `NWORDS`=1024: write to 0x1000 → `hresp`=1 with `hready`=0, then `hresp`=1 with `hready`=1. `mem[0]` is unchanged, and the next NONSEQ completes OKAY.
- `VSCALE_SRAM_ERRCHK_EN`: word read at 0x2 and `hsize`=3 at 0x0 → both give the two-cycle ERROR and `hrdata`=0. Without the macro, a word write at 0x1000 lands in `mem[0]`.
- IDLE/BUSY interleaved with SEQ beats at `WAIT_STATES`=1 → only the SEQ beats stall one cycle each, and the IDLE beats produce no stall.
